// File: rtl/wb_csr_commit.sv
// Writeback commit controller: CSR access, exception/ertn commit,
// pipeline flush and register-file write for the WB stage.
module wb_csr_commit #(
  parameter int FLUSH_HOLD = 1,
  parameter int INT_SYNC   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allow_in,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj_value,
  input  logic [31:0] ms_rkd_value,
  input  logic        ms_ertn,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_result,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_vaddr,
  output logic [31:0] wb_pc,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
  } ws_pl_t;

  localparam logic [1:0] HOLD = 2'(FLUSH_HOLD);

  ws_pl_t     pl_q;
  ws_pl_t     pl_d;
  logic       ws_valid;
  logic [1:0] hold_cnt;
  logic       int_q;
  logic       int_src;
  logic       take_int;
  logic       accept;
  logic       op_wr;
  logic       op_xchg;

  assign ws_allow_in = 1'b1;

  assign pl_d = '{
    pc:     ms_pc,
    op:     ms_csr_op,
    num:    ms_csr_num,
    rj:     ms_rj_value,
    rkd:    ms_rkd_value,
    ertn:   ms_ertn,
    ex:     ms_ex,
    ecode:  ms_ecode,
    esub:   ms_esubcode,
    vaddr:  ms_vaddr,
    rf_we:  ms_rf_we,
    waddr:  ms_rf_waddr,
    result: ms_result
  };

  assign accept = ms_to_ws_valid & ws_allow_in
                & ~flush & (hold_cnt == 2'd0);

  // WB valid, post-flush hold window and payload capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      hold_cnt <= 2'd0;
      pl_q     <= '0;
    end else begin
      if (flush) begin
        ws_valid <= 1'b0;
        hold_cnt <= HOLD;
      end else if (hold_cnt != 2'd0) begin
        ws_valid <= 1'b0;
        hold_cnt <= hold_cnt - 2'd1;
      end else begin
        ws_valid <= ms_to_ws_valid & ws_allow_in;
      end
      if (accept) pl_q <= pl_d;
    end
  end

  // interrupt request synchroniser
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) int_q <= 1'b0;
    else         int_q <= has_int;
  end

  assign int_src  = (INT_SYNC != 0) ? int_q : has_int;
  assign take_int = ws_valid & int_src;

  assign wb_ex      = ws_valid & (pl_q.ex | take_int);
  assign ertn_flush = ws_valid & pl_q.ertn & ~wb_ex;

  assign wb_ecode    = (wb_ex & ~take_int) ? pl_q.ecode : 6'h00;
  assign wb_esubcode = (wb_ex & ~take_int) ? pl_q.esub  : 9'h000;
  assign wb_vaddr    = wb_ex ? pl_q.vaddr : 32'h0;
  assign wb_pc       = ws_valid ? pl_q.pc : 32'h0;

  assign op_wr   = (pl_q.op == 2'b10);
  assign op_xchg = (pl_q.op == 2'b11);

  assign csr_re     = ws_valid & (pl_q.op != 2'b00);
  assign csr_num    = pl_q.num;
  assign csr_we     = ws_valid & (op_wr | op_xchg) & ~wb_ex;
  assign csr_wvalue = pl_q.rkd;

  // write mask: full word for csrwr, rj for csrxchg
  always_comb begin
    csr_wmask = 32'h0;
    unique case (1'b1)
      op_wr:   csr_wmask = 32'hFFFF_FFFF;
      op_xchg: csr_wmask = pl_q.rj;
      default: csr_wmask = 32'h0;
    endcase
  end

  assign rf_we    = ws_valid & pl_q.rf_we & ~wb_ex;
  assign rf_waddr = pl_q.waddr;
  assign rf_wdata = (pl_q.op != 2'b00) ? csr_rvalue : pl_q.result;

  assign flush        = wb_ex | ertn_flush;
  assign flush_target = wb_ex      ? ex_entry   :
                        ertn_flush ? ertn_entry : 32'h0;

  assign debug_wb_pc       = pl_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_csr_commit.sv
// Directed bench for wb_csr_commit: vector table plus
// hand sequences for flush hold, interrupt sync and reset.
module tb_wb_csr_commit;

  localparam logic [31:0] EXE = 32'h1C00_8000;
  localparam logic [31:0] ERE = 32'h1C00_0204;

  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_value;
  logic [31:0] ms_rkd_value;
  logic        ms_ertn;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [31:0] ms_vaddr;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_result;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;
  logic [31:0] wb_pc;
  logic        flush;
  logic [31:0] flush_target;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  wb_csr_commit #(.FLUSH_HOLD(1), .INT_SYNC(1)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_rj_value(ms_rj_value), .ms_rkd_value(ms_rkd_value),
    .ms_ertn(ms_ertn), .ms_ex(ms_ex), .ms_ecode(ms_ecode),
    .ms_esubcode(ms_esubcode), .ms_vaddr(ms_vaddr),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_result(ms_result),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_pc(wb_pc),
    .flush(flush), .flush_target(flush_target),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        rfwe;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic [31:0] rval;
    logic        e_re;
    logic        e_we;
    logic [31:0] e_mask;
    logic        e_ex;
    logic        e_ertn;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;
    logic [31:0] e_tgt;
    logic        e_rfwe;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ms_to_ws_valid = 1'b1;
    ms_pc          = v.pc;
    ms_csr_op      = v.op;
    ms_csr_num     = v.num;
    ms_rj_value    = v.rj;
    ms_rkd_value   = v.rkd;
    ms_ertn        = v.ertn;
    ms_ex          = v.ex;
    ms_ecode       = v.ecode;
    ms_esubcode    = v.esub;
    ms_vaddr       = v.vaddr;
    ms_rf_we       = v.rfwe;
    ms_rf_waddr    = v.waddr;
    ms_result      = v.result;
    csr_rvalue     = v.rval;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".allow"}, 32'(ws_allow_in), 32'd1);
    chk({tag, ".flush"}, 32'(flush), 32'd0);
    chk({tag, ".wb_ex"}, 32'(wb_ex), 32'd0);
    chk({tag, ".ertn"}, 32'(ertn_flush), 32'd0);
    chk({tag, ".csr_re"}, 32'(csr_re), 32'd0);
    chk({tag, ".csr_we"}, 32'(csr_we), 32'd0);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, ".wb_pc"}, wb_pc, 32'd0);
    chk({tag, ".tgt"}, flush_target, 32'd0);
  endtask

  initial begin
    vec_t a;
    vec_t b;
    vecs[0] = '{32'h1C00_0000, 2'b10, 14'h30, 32'h0, 32'h1234_5678,
                1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 1'b1, 5'd5,
                32'h0, 32'hDEAD_BEEF,
                1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 6'h00, 9'h000,
                32'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{32'h1C00_0004, 2'b11, 14'h04, 32'h0000_0FFF,
                32'hAAAA_5555, 1'b0, 1'b0, 6'h00, 9'h000, 32'h0,
                1'b1, 5'd6, 32'h0, 32'h1111_2222,
                1'b1, 1'b1, 32'h0000_0FFF, 1'b0, 1'b0, 6'h00, 9'h000,
                32'h0, 1'b1, 32'h1111_2222};
    vecs[2] = '{32'h1C00_0008, 2'b01, 14'h05, 32'hFFFF_0000,
                32'h0000_0077, 1'b0, 1'b0, 6'h00, 9'h000, 32'h0,
                1'b1, 5'd7, 32'h0000_5555, 32'hCAFE_0001,
                1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 6'h00, 9'h000,
                32'h0, 1'b1, 32'hCAFE_0001};
    vecs[3] = '{32'h1C00_000C, 2'b00, 14'h3FFF, 32'h0, 32'h0,
                1'b0, 1'b0, 6'h00, 9'h000, 32'h0, 1'b1, 5'd8,
                32'h0BAD_F00D, 32'h9999_9999,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h00, 9'h000,
                32'h0, 1'b1, 32'h0BAD_F00D};
    vecs[4] = '{32'h1C00_0100, 2'b10, 14'h30, 32'h0, 32'h0000_0001,
                1'b0, 1'b1, 6'h0B, 9'h000, 32'h0, 1'b1, 5'd9,
                32'h0, 32'h0000_0003,
                1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'h0B, 9'h000,
                EXE, 1'b0, 32'h0000_0003};
    vecs[5] = '{32'h1C00_0110, 2'b00, 14'h0, 32'h0, 32'h0,
                1'b1, 1'b0, 6'h00, 9'h000, 32'h0, 1'b0, 5'd0,
                32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6'h00, 9'h000,
                ERE, 1'b0, 32'h0};
    vecs[6] = '{32'h1C00_0120, 2'b00, 14'h0, 32'h0, 32'h0,
                1'b1, 1'b1, 6'h08, 9'h001, 32'h1234_567B, 1'b0, 5'd0,
                32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 6'h08, 9'h001,
                EXE, 1'b0, 32'h0};
    vecs[7] = '{32'h1C00_0130, 2'b00, 14'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 6'h3F, 9'h1FF, 32'hFFFF_FFFF, 1'b0, 5'd3,
                32'h0000_0042, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h00, 9'h000,
                32'h0, 1'b0, 32'h0000_0042};

    resetn = 1'b0;
    ms_to_ws_valid = 1'b0;
    a = vecs[3];
    drive(a);
    ms_to_ws_valid = 1'b0;
    has_int = 1'b0;
    ex_entry = EXE;
    ertn_entry = ERE;
    #12;
    chk_quiet("rst");
    chk("rst.dbg_pc", debug_wb_pc, 32'd0);
    chk("rst.wdata", rf_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      string t;
      vec_t v;
      v = vecs[i];
      t = $sformatf("v%0d", i);
      @(negedge clk);
      drive(v);
      @(posedge clk);
      #1;
      chk({t, ".csr_re"}, 32'(csr_re), 32'(v.e_re));
      chk({t, ".csr_num"}, 32'(csr_num), 32'(v.num));
      chk({t, ".csr_we"}, 32'(csr_we), 32'(v.e_we));
      chk({t, ".wmask"}, csr_wmask, v.e_mask);
      chk({t, ".wvalue"}, csr_wvalue, v.rkd);
      chk({t, ".wb_ex"}, 32'(wb_ex), 32'(v.e_ex));
      chk({t, ".ertn"}, 32'(ertn_flush), 32'(v.e_ertn));
      chk({t, ".ecode"}, 32'(wb_ecode), 32'(v.e_ecode));
      chk({t, ".esub"}, 32'(wb_esubcode), 32'(v.e_esub));
      chk({t, ".vaddr"}, wb_vaddr, v.e_ex ? v.vaddr : 32'h0);
      chk({t, ".wb_pc"}, wb_pc, v.pc);
      chk({t, ".flush"}, 32'(flush), 32'(v.e_ex | v.e_ertn));
      chk({t, ".tgt"}, flush_target, v.e_tgt);
      chk({t, ".rf_we"}, 32'(rf_we), 32'(v.e_rfwe));
      chk({t, ".waddr"}, 32'(debug_wb_rf_wnum), 32'(v.waddr));
      chk({t, ".wdata"}, debug_wb_rf_wdata, v.e_wdata);
      chk({t, ".dbg_we"}, 32'(debug_wb_rf_we), {28'h0, {4{v.e_rfwe}}});
      chk({t, ".dbg_pc"}, debug_wb_pc, v.pc);
      idle(3);
    end

    // flush hold: arrivals in flush cycle and the one after are dropped
    a = vecs[4];
    b = vecs[3];
    b.pc = 32'h1C00_0200;
    @(negedge clk);
    drive(a);
    @(posedge clk);
    #1;
    chk("hold.flush", 32'(flush), 32'd1);
    @(negedge clk);
    drive(b);
    @(posedge clk);
    #1;
    chk("hold.drop1", 32'(rf_we), 32'd0);
    chk("hold.drop1_pc", wb_pc, 32'd0);
    @(posedge clk);
    #1;
    chk("hold.drop2", 32'(rf_we), 32'd0);
    @(posedge clk);
    #1;
    chk("hold.accept", 32'(rf_we), 32'd1);
    chk("hold.accept_pc", wb_pc, 32'h1C00_0200);
    chk("hold.noflush", 32'(flush), 32'd0);
    idle(3);

    // interrupt is sampled, then taken by the following instruction
    a = vecs[0];
    b = vecs[4];
    b.pc = 32'h1C00_0300;
    @(negedge clk);
    drive(a);
    @(posedge clk);
    #1;
    chk("int.a_we", 32'(csr_we), 32'd1);
    @(negedge clk);
    has_int = 1'b1;
    drive(b);
    #1;
    chk("int.sync_ex", 32'(wb_ex), 32'd0);
    chk("int.sync_we", 32'(csr_we), 32'd1);
    @(posedge clk);
    #1;
    chk("int.wb_ex", 32'(wb_ex), 32'd1);
    chk("int.ecode", 32'(wb_ecode), 32'd0);
    chk("int.csr_we", 32'(csr_we), 32'd0);
    chk("int.wb_pc", wb_pc, 32'h1C00_0300);
    chk("int.tgt", flush_target, EXE);
    @(negedge clk);
    has_int = 1'b0;
    ms_to_ws_valid = 1'b0;
    repeat (3) @(posedge clk);

    // reset while the hold counter is loaded
    a = vecs[5];
    b = vecs[3];
    b.pc = 32'h1C00_0400;
    @(negedge clk);
    drive(a);
    @(posedge clk);
    #1;
    chk("rmh.ertn", 32'(ertn_flush), 32'd1);
    @(negedge clk);
    drive(b);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_quiet("rmh");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rmh.first_we", 32'(rf_we), 32'd1);
    chk("rmh.first_pc", wb_pc, 32'h1C00_0400);
    chk("rmh.first_wd", rf_wdata, 32'h0BAD_F00D);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
